// File: rtl/snn_pkg.sv
// Shared definitions for the SNN motor path: steering command codes and decoder FSM states.
// No timing of its own.
// No flow control of its own.
package snn_pkg;

  // Steering command encoding seen by the motor driver
  localparam logic [1:0] CMD_STOP    = 2'b00;
  localparam logic [1:0] CMD_LEFT    = 2'b01;
  localparam logic [1:0] CMD_RIGHT   = 2'b10;
  localparam logic [1:0] CMD_FORWARD = 2'b11;

  // Rate decoder control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCUM  = 2'b01,
    ST_DECIDE = 2'b10
  } state_t;

endpackage

// File: rtl/spike_rate_counter.sv
// Saturating per-channel spike counter with close/clear and a snapshot of the closed window.
// Latency: snapshot valid the cycle after the close cycle; a close-cycle spike lands in the snapshot.
// No backpressure: en=0 freezes count and snapshot; spikes seen while en=0 are ignored.
module spike_rate_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike,
  input  logic             close,
  output logic [CNT_W-1:0] snap
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Count including this cycle's spike, held at the ceiling instead of wrapping
  assign cnt_inc = (spike && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;

  // Accumulate; on close hand the total (with the closing spike) to the snapshot and restart at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      snap <= '0;
    end else if (en) begin
      if (close) begin
        snap <= cnt_inc;
        cnt  <= '0;
      end else begin
        cnt  <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/spike_motor_decoder.sv
// Rate decoder: counts Left/Right spikes over WIN_LEN enabled cycles and converts them to a steering command.
// Latency: window close cycle N -> cmd and cmd_valid visible at enabled cycle N+2.
// No backpressure: en=0 freezes all state and masks cmd_valid; a pending decision waits for en to return.
module spike_motor_decoder
  import snn_pkg::*;
#(
  parameter int WIN_LEN    = 1000,
  parameter int CNT_W      = 10,
  parameter int DIFF_TH    = 3,
  parameter int MIN_SPIKES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       spike_in,
  output logic [1:0]       cmd,
  output logic             cmd_valid,
  output logic [CNT_W-1:0] rate_left,
  output logic [CNT_W-1:0] rate_right
);
  localparam int               WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [CNT_W:0]   MIN_EXT  = (CNT_W+1)'(MIN_SPIKES);
  localparam logic [CNT_W:0]   TH_EXT   = (CNT_W+1)'(DIFF_TH);

  state_t           state;
  state_t           state_nxt;
  logic [WIN_W-1:0] win_cnt;
  logic             close;
  logic             valid_q;
  logic [1:0]       decision;
  logic [CNT_W:0]   l_ext;
  logic [CNT_W:0]   r_ext;
  logic [CNT_W:0]   sum;

  assign close = en && (win_cnt == WIN_LAST);

  // Window position; runs on every enabled cycle so windows abut with no gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
    end else if (en) begin
      win_cnt <= close ? '0 : win_cnt + WIN_W'(1);
    end
  end

  spike_rate_counter #(.CNT_W(CNT_W)) u_left (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .spike (spike_in[0]),
    .close (close),
    .snap  (rate_left)
  );

  spike_rate_counter #(.CNT_W(CNT_W)) u_right (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .spike (spike_in[1]),
    .close (close),
    .snap  (rate_right)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: decide one enabled cycle after each close
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (en)    state_nxt = ST_ACCUM;
      ST_ACCUM:  if (close) state_nxt = ST_DECIDE;
      ST_DECIDE: if (en)    state_nxt = ST_ACCUM;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // Steering decision from the latched window rates, one bit wider so sums never overflow
  always_comb begin
    l_ext    = {1'b0, rate_left};
    r_ext    = {1'b0, rate_right};
    sum      = l_ext + r_ext;
    decision = CMD_FORWARD;
    if (sum < MIN_EXT) begin
      decision = CMD_STOP;
    end else if (l_ext >= r_ext + TH_EXT) begin
      decision = CMD_LEFT;
    end else if (r_ext >= l_ext + TH_EXT) begin
      decision = CMD_RIGHT;
    end
  end

  // Register the command at the end of DECIDE and flag it for the following enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd     <= CMD_STOP;
      valid_q <= 1'b0;
    end else if (en) begin
      valid_q <= (state == ST_DECIDE);
      if (state == ST_DECIDE) begin
        cmd <= decision;
      end
    end
  end

  // A pulse pending across an en=0 stretch stays held and is shown once en returns
  assign cmd_valid = valid_q & en;

endmodule

// File: tb/tb_spike_motor_decoder.sv
// Bench for spike_motor_decoder: directed scenarios plus randomized traffic against a window-level model.
// Two instances (10-bit and 3-bit counters) share the same stimulus.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_spike_motor_decoder;
  localparam int WIN    = 16;
  localparam int DTH    = 3;
  localparam int MIN_SP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] spike_in = 2'b00;

  logic [1:0] cmd_a, cmd_s;
  logic       vld_a, vld_s;
  logic [9:0] rl_a, rr_a;
  logic [2:0] rl_s, rr_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_motor_decoder #(.WIN_LEN(WIN), .CNT_W(10), .DIFF_TH(DTH), .MIN_SPIKES(MIN_SP)) dut_a (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .cmd(cmd_a), .cmd_valid(vld_a), .rate_left(rl_a), .rate_right(rr_a)
  );

  spike_motor_decoder #(.WIN_LEN(WIN), .CNT_W(3), .DIFF_TH(DTH), .MIN_SPIKES(MIN_SP)) dut_s (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .cmd(cmd_s), .cmd_valid(vld_s), .rate_left(rl_s), .rate_right(rr_s)
  );

  // Observed outputs per instance, widened to a common width
  logic [1:0] cmd_o [2];
  logic       vld_o [2];
  logic [9:0] rl_o  [2];
  logic [9:0] rr_o  [2];
  assign cmd_o[0] = cmd_a;
  assign cmd_o[1] = cmd_s;
  assign vld_o[0] = vld_a;
  assign vld_o[1] = vld_s;
  assign rl_o[0]  = rl_a;
  assign rl_o[1]  = {7'd0, rl_s};
  assign rr_o[0]  = rr_a;
  assign rr_o[1]  = {7'd0, rr_s};

  // Window-level reference model: m_e counts enabled cycles since reset
  int m_e;
  int m_close;
  int m_acc  [2][2];
  int m_rate [2][2];
  int m_cmd  [2];
  int m_pend [2];
  int m_max  [2] = '{1023, 7};

  function automatic int decide(int l, int r);
    if (l + r < MIN_SP) return 0;
    if (l >= r + DTH)   return 1;
    if (r >= l + DTH)   return 2;
    return 3;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e = 0;
      m_close = -100;
      for (int k = 0; k < 2; k++) begin
        m_cmd[k] = 0;
        m_pend[k] = 0;
        for (int c = 0; c < 2; c++) begin
          m_acc[k][c] = 0;
          m_rate[k][c] = 0;
        end
      end
    end else if (en) begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 2; c++) begin
          m_acc[k][c] = m_acc[k][c] + int'(spike_in[c]);
          if (m_acc[k][c] > m_max[k]) m_acc[k][c] = m_max[k];
        end
      if (m_e == m_close + 1)
        for (int k = 0; k < 2; k++) m_cmd[k] = m_pend[k];
      if (m_e % WIN == WIN - 1) begin
        for (int k = 0; k < 2; k++) begin
          for (int c = 0; c < 2; c++) begin
            m_rate[k][c] = m_acc[k][c];
            m_acc[k][c] = 0;
          end
          m_pend[k] = decide(m_rate[k][0], m_rate[k][1]);
        end
        m_close = m_e;
      end
      m_e = m_e + 1;
    end
  end

  task automatic step(input logic e, input logic [1:0] s);
    @(negedge clk);
    en = e;
    spike_in = s;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    spike_in = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Enabled cycles first..WIN-1 of a window; spikes sit at the end of the window
  task automatic run_win(input int nl, input int nr, input int first);
    for (int i = first; i < WIN; i++)
      step(1'b1, {1'(i >= WIN - nr), 1'(i >= WIN - nl)});
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; spike_in = 2'b00;
    #1;
    checks++;
    if ({cmd_a, vld_a, rl_a, rr_a} !== 23'd0) begin
      errors++; $display("FAIL reset_state got cmd=%0d vld=%0d rl=%0d rr=%0d want all 0", cmd_a, vld_a, rl_a, rr_a);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 21; i++) step(1'b1, 2'b01);
    checks++;
    if (rl_a !== 10'd16 || cmd_a !== 2'd1) begin
      errors++; $display("FAIL pre_reset_window got rl=%0d cmd=%0d want rl=16 cmd=1", rl_a, cmd_a);
    end
    @(negedge clk); #3;
    rst = 1'b1; en = 1'b0;
    #1;
    checks++;
    if ({cmd_a, vld_a, rl_a, rr_a, cmd_s, vld_s, rl_s, rr_s} !== 32'd0) begin
      errors++; $display("FAIL async_reset got cmd=%0d vld=%0d rl=%0d rr=%0d want all 0", cmd_a, vld_a, rl_a, rr_a);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < WIN + 1; i++) begin
      step(1'b1, 2'b00);
      checks++;
      if (vld_a !== 1'b0) begin
        errors++; $display("FAIL post_reset_quiet cycle %0d got vld=%0d want 0", i, vld_a);
      end
    end
    step(1'b1, 2'b00);
    checks++;
    if (vld_a !== 1'b1 || cmd_a !== 2'd0) begin
      errors++; $display("FAIL post_reset_first_cmd got vld=%0d cmd=%0d want vld=1 cmd=0", vld_a, cmd_a);
    end
  endtask

  task automatic test_turn_left();
    do_reset();
    run_win(8, 2, 0);
    step(1'b1, 2'b00);
    checks++;
    if (rl_a !== 10'd8 || rr_a !== 10'd2 || vld_a !== 1'b0 || cmd_a !== 2'd0) begin
      errors++; $display("FAIL turn_left_decide got rl=%0d rr=%0d vld=%0d cmd=%0d want 8 2 0 0", rl_a, rr_a, vld_a, cmd_a);
    end
    step(1'b1, 2'b00);
    checks++;
    if (vld_a !== 1'b1 || cmd_a !== 2'd1) begin
      errors++; $display("FAIL turn_left_cmd got vld=%0d cmd=%0d want vld=1 cmd=1", vld_a, cmd_a);
    end
    step(1'b1, 2'b00);
    checks++;
    if (vld_a !== 1'b0 || cmd_a !== 2'd1) begin
      errors++; $display("FAIL turn_left_pulse_width got vld=%0d cmd=%0d want vld=0 cmd=1", vld_a, cmd_a);
    end
  endtask

  task automatic test_forward_stop();
    run_win(5, 4, 3);
    step(1'b1, 2'b00);
    checks++;
    if (rl_a !== 10'd5 || rr_a !== 10'd4) begin
      errors++; $display("FAIL forward_rates got rl=%0d rr=%0d want 5 4", rl_a, rr_a);
    end
    step(1'b1, 2'b00);
    checks++;
    if (vld_a !== 1'b1 || cmd_a !== 2'd3) begin
      errors++; $display("FAIL forward_cmd got vld=%0d cmd=%0d want vld=1 cmd=3", vld_a, cmd_a);
    end
    run_win(0, 0, 2);
    step(1'b1, 2'b00);
    checks++;
    if (rl_a !== 10'd0 || rr_a !== 10'd0) begin
      errors++; $display("FAIL silent_rates got rl=%0d rr=%0d want 0 0", rl_a, rr_a);
    end
    step(1'b1, 2'b00);
    checks++;
    if (vld_a !== 1'b1 || cmd_a !== 2'd0) begin
      errors++; $display("FAIL silent_cmd got vld=%0d cmd=%0d want vld=1 cmd=0", vld_a, cmd_a);
    end
  endtask

  task automatic test_close_boundary();
    do_reset();
    for (int i = 0; i < WIN - 1; i++) step(1'b1, 2'b00);
    step(1'b1, 2'b10);
    step(1'b1, 2'b10);
    checks++;
    if (rr_a !== 10'd1 || rl_a !== 10'd0) begin
      errors++; $display("FAIL boundary_first_window got rl=%0d rr=%0d want 0 1", rl_a, rr_a);
    end
    step(1'b1, 2'b00);
    checks++;
    if (vld_a !== 1'b1 || cmd_a !== 2'd3) begin
      errors++; $display("FAIL boundary_cmd got vld=%0d cmd=%0d want vld=1 cmd=3", vld_a, cmd_a);
    end
    run_win(0, 0, 2);
    step(1'b1, 2'b00);
    checks++;
    if (rr_a !== 10'd1 || rl_a !== 10'd0) begin
      errors++; $display("FAIL boundary_second_window got rl=%0d rr=%0d want 0 1", rl_a, rr_a);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < WIN; i++) step(1'b1, 2'b01);
    step(1'b1, 2'b00);
    checks++;
    if (rl_s !== 3'd7 || rl_a !== 10'd16) begin
      errors++; $display("FAIL saturation_rate got narrow=%0d wide=%0d want 7 16", rl_s, rl_a);
    end
    step(1'b1, 2'b00);
    checks++;
    if (vld_s !== 1'b1 || cmd_s !== 2'd1) begin
      errors++; $display("FAIL saturation_cmd got vld=%0d cmd=%0d want vld=1 cmd=1", vld_s, cmd_s);
    end
  endtask

  task automatic test_enable_gating();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 2'b01);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b11);
    for (int i = 8; i < WIN; i++) step(1'b1, {1'(i < 10), 1'b0});
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b11);
      checks++;
      if (vld_a !== 1'b0 || cmd_a !== 2'd0 || rl_a !== 10'd8 || rr_a !== 10'd2) begin
        errors++; $display("FAIL gating_hold cycle %0d got vld=%0d cmd=%0d rl=%0d rr=%0d want 0 0 8 2", i, vld_a, cmd_a, rl_a, rr_a);
      end
    end
    step(1'b1, 2'b00);
    checks++;
    if (vld_a !== 1'b0) begin
      errors++; $display("FAIL gating_decide got vld=%0d want 0", vld_a);
    end
    step(1'b1, 2'b00);
    checks++;
    if (vld_a !== 1'b1 || cmd_a !== 2'd1) begin
      errors++; $display("FAIL gating_cmd got vld=%0d cmd=%0d want vld=1 cmd=1", vld_a, cmd_a);
    end
  endtask

  task automatic test_random();
    int dl, dr;
    logic e;
    logic [1:0] s;
    logic exp_vld;
    do_reset();
    dl = 30; dr = 30;
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) begin
        dl = $urandom_range(0, 100);
        dr = $urandom_range(0, 100);
      end
      e = 1'($urandom_range(0, 99) < 85);
      s[0] = 1'($urandom_range(0, 99) < dl);
      s[1] = 1'($urandom_range(0, 99) < dr);
      step(e, s);
      exp_vld = e && (m_e == m_close + 2);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (vld_o[k] !== exp_vld || cmd_o[k] !== 2'(m_cmd[k]) ||
            rl_o[k] !== 10'(m_rate[k][0]) || rr_o[k] !== 10'(m_rate[k][1])) begin
          errors++;
          $display("FAIL random inst%0d cycle %0d got vld=%0d cmd=%0d rl=%0d rr=%0d want %0d %0d %0d %0d",
                   k, n, vld_o[k], cmd_o[k], rl_o[k], rr_o[k], exp_vld, m_cmd[k], m_rate[k][0], m_rate[k][1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_turn_left();
    test_forward_stop();
    test_close_boundary();
    test_saturation();
    test_enable_gating();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
